// File: rtl/boa_lsu_if.sv
// Request/response and memory-bus bundle for the boa load/store unit.
// The slave modport is the LSU's view; master is the CPU pipeline plus memory side.
interface boa_lsu_if #(
    parameter int XLEN = 32
);
    logic              clear;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_asize;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic [1:0]        rsp_fault;
    logic              bus_re;
    logic [XLEN/8-1:0] bus_we;
    logic [31:0]       bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_ready;
    logic [XLEN-1:0]   bus_rdata;

    modport slave (
        input  clear, req_valid, req_we, req_asize, req_signed, req_addr, req_wdata,
        input  bus_ready, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
        output bus_re, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output clear, req_valid, req_we, req_asize, req_signed, req_addr, req_wdata,
        output bus_ready, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
        input  bus_re, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/boa_lsu.sv
// MEM-stage load/store unit: lane steering, sign/zero extension, optional split of crossing accesses.
// Response 2 cycles after accept (3 if split, 1 on fault) with zero bus wait; strobes held until bus_ready.
module boa_lsu #(
    parameter int XLEN           = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    boa_lsu_if.slave  io
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RESP, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        asize_q, asize_d;
    logic              signed_q, signed_d;
    logic [OW-1:0]     off_q, off_d;
    logic              cross_q, cross_d;
    logic [NB-1:0]     we1_q, we1_d;
    logic [XLEN-1:0]   wdata1_q, wdata1_d;
    logic [XLEN-1:0]   rd_lo_q, rd_lo_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_fault_q, rsp_fault_d;
    logic              bus_re_q, bus_re_d;
    logic [NB-1:0]     bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;

    logic [OW-1:0]     req_off;
    logic [3:0]        req_bytes;
    logic [4:0]        req_end;
    logic              req_cross;
    logic              req_illegal;
    logic [NB-1:0]     size_mask;
    logic [XLEN-1:0]   wd_sized;
    logic [2*NB-1:0]   lanes_w;
    logic [2*XLEN-1:0] data_w;
    logic [2*XLEN-1:0] rd_cat;
    logic [XLEN-1:0]   rd_sh;
    logic [XLEN-1:0]   ld_ext;

    // Request classification and two-beat lane/data images, both beats computed at accept time.
    always_comb begin
        req_off     = io.req_addr[OW-1:0];
        req_bytes   = 4'd1 << io.req_asize;
        req_end     = 5'(req_off) + 5'(req_bytes);
        req_cross   = req_end > 5'(NB);
        req_illegal = (XLEN == 32) && (io.req_asize == 2'd3);
        size_mask   = '0;
        wd_sized    = '0;
        for (int i = 0; i < NB; i++) begin
            size_mask[i]     = i < int'(req_bytes);
            wd_sized[8*i +: 8] = size_mask[i] ? io.req_wdata[8*i +: 8] : 8'h00;
        end
        lanes_w = {{NB{1'b0}}, size_mask} << req_off;
        data_w  = {{XLEN{1'b0}}, wd_sized} << {req_off, 3'b000};
    end

    // Read merge: beat1 bytes sit above beat0 bytes, then shift the access down to bit 0.
    always_comb begin
        rd_cat = (state_q == BEAT1) ? {io.bus_rdata, rd_lo_q} : {{XLEN{1'b0}}, io.bus_rdata};
        rd_sh  = XLEN'(rd_cat >> {off_q, 3'b000});
        case (asize_q)
            2'd0:    ld_ext = XLEN'({{56{signed_q & rd_sh[7]}},  rd_sh[7:0]});
            2'd1:    ld_ext = XLEN'({{48{signed_q & rd_sh[15]}}, rd_sh[15:0]});
            2'd2:    ld_ext = XLEN'({{32{signed_q & rd_sh[31]}}, rd_sh[31:0]});
            default: ld_ext = rd_sh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        asize_d     = asize_q;
        signed_d    = signed_q;
        off_d       = off_q;
        cross_d     = cross_q;
        we1_d       = we1_q;
        wdata1_d    = wdata1_q;
        rd_lo_d     = rd_lo_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        bus_re_d    = bus_re_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        case (state_q)
            IDLE: begin
                if (io.req_valid && !io.clear) begin
                    we_d     = io.req_we;
                    asize_d  = io.req_asize;
                    signed_d = io.req_signed;
                    off_d    = req_off;
                    cross_d  = req_cross;
                    we1_d    = lanes_w[2*NB-1:NB];
                    wdata1_d = data_w[2*XLEN-1:XLEN];
                    if (req_illegal || (req_cross && !ALLOW_MISALIGN)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_fault_d = req_illegal ? 2'd2 : 2'd1;
                    end else begin
                        state_d     = BEAT0;
                        bus_addr_d  = {io.req_addr[31:OW], {OW{1'b0}}};
                        bus_re_d    = !io.req_we;
                        bus_we_d    = io.req_we ? lanes_w[NB-1:0] : '0;
                        bus_wdata_d = io.req_we ? data_w[XLEN-1:0] : '0;
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (io.bus_ready) begin
                    rd_lo_d = (state_q == BEAT0) ? io.bus_rdata : rd_lo_q;
                    if (!io.clear && state_q == BEAT0 && cross_q) begin
                        state_d     = BEAT1;
                        bus_addr_d  = bus_addr_q + 32'(NB);
                        bus_we_d    = we_q ? we1_q : '0;
                        bus_wdata_d = we_q ? wdata1_q : '0;
                    end else begin
                        state_d     = io.clear ? IDLE : RESP;
                        rsp_valid_d = !io.clear;
                        rsp_rdata_d = io.clear ? rsp_rdata_q : (we_q ? '0 : ld_ext);
                        rsp_fault_d = io.clear ? rsp_fault_q : 2'd0;
                        bus_re_d    = 1'b0;
                        bus_we_d    = '0;
                        bus_wdata_d = '0;
                    end
                end else if (io.clear) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A started beat is never withdrawn; finish it silently.
                if (io.bus_ready) begin
                    state_d     = IDLE;
                    bus_re_d    = 1'b0;
                    bus_we_d    = '0;
                    bus_wdata_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            asize_q     <= 2'd0;
            signed_q    <= 1'b0;
            off_q       <= '0;
            cross_q     <= 1'b0;
            we1_q       <= '0;
            wdata1_q    <= '0;
            rd_lo_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 2'd0;
            bus_re_q    <= 1'b0;
            bus_we_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            asize_q     <= asize_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            cross_q     <= cross_d;
            we1_q       <= we1_d;
            wdata1_q    <= wdata1_d;
            rd_lo_q     <= rd_lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            bus_re_q    <= bus_re_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // clear in RESP must swallow the pulse in the same cycle, hence the gate after the flop.
    assign io.req_ready = (state_q == IDLE) && !io.clear;
    assign io.rsp_valid = rsp_valid_q && !io.clear;
    assign io.rsp_rdata = rsp_rdata_q;
    assign io.rsp_fault = rsp_fault_q;
    assign io.bus_re    = bus_re_q;
    assign io.bus_we    = bus_we_q;
    assign io.bus_addr  = bus_addr_q;
    assign io.bus_wdata = bus_wdata_q;
endmodule
